// File: rtl/bitplane_context_gen.sv
// -----------------------------------------------------------------------------
// bitplane_context_gen
//
// Purpose:
//   Takes one 3x3 window of sign-magnitude coefficients and scans the centre
//   coefficient from bitplane TOP_PLANE down to 0. It emits one coding symbol
//   per accepted cycle. Each symbol carries the centre bit at that plane and
//   its significance/refinement/sign flags. It also carries a 0..8
//   significance context built from the eight neighbours. The context table
//   used depends on the subband orientation.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   bitplane_input_valid        a window is presented on bitplane_data0..8
//   bitplane_data0..8 [15:0]    window in raster order, data4 = centre;
//                               bit15 = sign, bits14:0 = magnitude
//   subband [2:0]               0=LL 1=LH 3=HL 4=HH (others behave as LL)
//   bitplane_code_ready         registered; block is idle and takes a window
//   code_accept                 downstream consumes the current symbol
//   code_valid                  a symbol is being presented
//   code_bit/sign/newsig/refine symbol payload
//   code_context [3:0]          neighbourhood context 0..8
//   code_plane [3:0]            bitplane of this symbol
//   code_subband [2:0]          subband latched with the window
//   code_last                   symbol for plane 0 (end of this window)
// -----------------------------------------------------------------------------
module bitplane_context_gen #(
  parameter int TOP_PLANE = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bitplane_input_valid,
  input  logic [15:0] bitplane_data0,
  input  logic [15:0] bitplane_data1,
  input  logic [15:0] bitplane_data2,
  input  logic [15:0] bitplane_data3,
  input  logic [15:0] bitplane_data4,
  input  logic [15:0] bitplane_data5,
  input  logic [15:0] bitplane_data6,
  input  logic [15:0] bitplane_data7,
  input  logic [15:0] bitplane_data8,
  input  logic [2:0]  subband,
  output logic        bitplane_code_ready,
  input  logic        code_accept,
  output logic        code_valid,
  output logic        code_bit,
  output logic        code_sign,
  output logic        code_newsig,
  output logic        code_refine,
  output logic [3:0]  code_context,
  output logic [3:0]  code_plane,
  output logic [2:0]  code_subband,
  output logic        code_last
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [2:0] SB_HL = 3'd3;
  localparam logic [2:0] SB_HH = 3'd4;

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic [3:0]  plane_q, plane_d;
  logic [14:0] mag_q [9];
  logic        sign_q;
  logic [2:0]  sb_q;
  logic        capture;

  logic [14:0] win_mag [9];

  assign win_mag[0] = bitplane_data0[14:0];
  assign win_mag[1] = bitplane_data1[14:0];
  assign win_mag[2] = bitplane_data2[14:0];
  assign win_mag[3] = bitplane_data3[14:0];
  assign win_mag[4] = bitplane_data4[14:0];
  assign win_mag[5] = bitplane_data5[14:0];
  assign win_mag[6] = bitplane_data6[14:0];
  assign win_mag[7] = bitplane_data7[14:0];
  assign win_mag[8] = bitplane_data8[14:0];

  // Only the centre sign is ever coded; neighbour signs are unused.
  logic unused_sign_bits;
  assign unused_sign_bits = ^{bitplane_data0[15], bitplane_data1[15], bitplane_data2[15],
                              bitplane_data3[15], bitplane_data5[15], bitplane_data6[15],
                              bitplane_data7[15], bitplane_data8[15]};

  // A coefficient is significant at plane p once any bit above p is set.
  function automatic logic sig_at(input logic [14:0] m, input logic [3:0] p);
    logic [15:0] ext;
    ext = {1'b0, m};
    return (ext >> ({1'b0, p} + 5'd1)) != 16'd0;
  endfunction

  // LL/LH table; HL reuses it with the horizontal and vertical counts swapped.
  function automatic logic [3:0] ctx_lh(input logic [1:0] h, input logic [1:0] v,
                                        input logic [2:0] d);
    if (h == 2'd2)                        return 4'd8;
    else if (h == 2'd1) begin
      if (v != 2'd0)                      return 4'd7;
      else if (d != 3'd0)                 return 4'd6;
      else                                return 4'd5;
    end
    else if (v == 2'd2)                   return 4'd4;
    else if (v == 2'd1)                   return 4'd3;
    else if (d >= 3'd2)                   return 4'd2;
    else if (d == 3'd1)                   return 4'd1;
    else                                  return 4'd0;
  endfunction

  // HH is driven mainly by the diagonals, then by the combined h+v count.
  function automatic logic [3:0] ctx_hh(input logic [1:0] h, input logic [1:0] v,
                                        input logic [2:0] d);
    logic [2:0] s;
    s = {1'b0, h} + {1'b0, v};
    if (d >= 3'd3)                        return 4'd8;
    else if (d == 3'd2)                   return (s != 3'd0) ? 4'd7 : 4'd6;
    else if (d == 3'd1) begin
      if (s >= 3'd2)                      return 4'd5;
      else if (s == 3'd1)                 return 4'd4;
      else                                return 4'd3;
    end
    else if (s >= 3'd2)                   return 4'd2;
    else if (s == 3'd1)                   return 4'd1;
    else                                  return 4'd0;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    plane_d = plane_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready_q && bitplane_input_valid) begin
          capture = 1'b1;
          state_d = SCAN;
          plane_d = 4'(TOP_PLANE);
        end
      end
      SCAN: begin
        if (code_accept) begin
          if (plane_q == 4'd0) state_d = IDLE;
          else                 plane_d = plane_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready is a register that tracks the state being entered, so it rises
    // together with the return to IDLE and on the first edge after reset.
    ready_d = (state_d == IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and window registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      plane_q <= 4'd0;
      sign_q  <= 1'b0;
      sb_q    <= 3'd0;
      // NOTE: the window store is reset as well. It is only nine words, and
      // clearing it keeps a discarded window from leaking into later symbols.
      for (int i = 0; i < 9; i++) mag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      plane_q <= plane_d;
      if (capture) begin
        for (int i = 0; i < 9; i++) mag_q[i] <= win_mag[i];
        sign_q <= bitplane_data4[15];
        sb_q   <= subband;
      end
    end
  end

  assign bitplane_code_ready = ready_q;

  // ---------------------------------------------------------------------------
  // Symbol generation (purely from registers, so it holds while stalled)
  // ---------------------------------------------------------------------------
  logic       in_scan;
  logic       cen_refine, cen_bit;
  logic [1:0] cnt_h, cnt_v;
  logic [2:0] cnt_d;

  assign in_scan    = (state_q == SCAN);
  assign cen_refine = sig_at(mag_q[4], plane_q);
  assign cen_bit    = mag_q[4][plane_q];
  assign cnt_h      = {1'b0, sig_at(mag_q[3], plane_q)} + {1'b0, sig_at(mag_q[5], plane_q)};
  assign cnt_v      = {1'b0, sig_at(mag_q[1], plane_q)} + {1'b0, sig_at(mag_q[7], plane_q)};
  assign cnt_d      = {2'b0, sig_at(mag_q[0], plane_q)} + {2'b0, sig_at(mag_q[2], plane_q)}
                    + {2'b0, sig_at(mag_q[6], plane_q)} + {2'b0, sig_at(mag_q[8], plane_q)};

  always_comb begin
    code_valid   = 1'b0;
    code_bit     = 1'b0;
    code_sign    = 1'b0;
    code_newsig  = 1'b0;
    code_refine  = 1'b0;
    code_context = 4'd0;
    code_plane   = 4'd0;
    code_subband = 3'd0;
    code_last    = 1'b0;
    if (in_scan) begin
      code_valid   = 1'b1;
      code_bit     = cen_bit;
      code_refine  = cen_refine;
      code_newsig  = !cen_refine && cen_bit;
      code_sign    = (!cen_refine && cen_bit) ? sign_q : 1'b0;
      code_plane   = plane_q;
      code_subband = sb_q;
      code_last    = (plane_q == 4'd0);
      case (sb_q)
        SB_HL:   code_context = ctx_lh(cnt_v, cnt_h, cnt_d);
        SB_HH:   code_context = ctx_hh(cnt_h, cnt_v, cnt_d);
        default: code_context = ctx_lh(cnt_h, cnt_v, cnt_d);
      endcase
    end
  end

endmodule
